rx_stream_checker: RTL

- Synthesizable in-order byte-stream checker for the RGMII receive path. Replaces the fixed single-byte, fatal-on-mismatch bench check.
- Expected beats are queued in an internal FIFO. Each received beat is compared against the FIFO head.
- Per-frame pass/fail and running match/error counters are reported.
- Sits on the local receive clock after the RGMII DDR-to-byte stage. Usable in simulation and on hardware as a loopback self-check.

---
 rtl/rx_chk_pkg.sv | 17 +
 rtl/sync_fifo.sv | 73 +++++++
 rtl/rx_stream_checker.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/rx_chk_pkg.sv
// Shared types and helpers for the rx_stream_checker slice.
package rx_chk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } chk_state_e;

    // Saturating increment on a value of the given width (width <= 63).
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
        logic [63:0] max_val;
        max_val = (64'd1 << width) - 64'd1;
        return (val >= max_val) ? val : val + 64'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered "can push" flag; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             can_push
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             can_push_q;
    logic             do_push, do_pop;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign rdata    = mem_q[rd_ptr_q];
    assign can_push = can_push_q;

    // Next occupancy; clear wins over any push/pop.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, occupancy and the registered ready flag (low while in reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            can_push_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            can_push_q <= (count_d != DEPTH_CNT);
            if (clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/rx_stream_checker.sv
// In-order byte-stream checker for the RGMII receive path.
// Expected beats are queued in sync_fifo and compared with received beats.
// Optional error capture ports: define RX_STREAM_CHECKER_ERR_CAPTURE_EN.
module rx_stream_checker
    import rx_chk_pkg::*;
#(
    parameter int unsigned LANES = 1,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic               rxClkLcl,
    input  logic               rstN,
    input  logic               clear,
    input  logic [8*LANES-1:0] expData,
    input  logic               expValid,
    output logic               expReady,
    input  logic [8*LANES-1:0] rxData,
    input  logic               rxDataValid,
    input  logic               rxLast,
    output logic               frameDone,
    output logic               frameOk,
    output logic [CNT_W-1:0]   matchCnt,
    output logic [CNT_W-1:0]   errCnt,
    output logic [CNT_W-1:0]   frameCnt,
    output logic               underflow,
`ifdef RX_STREAM_CHECKER_ERR_CAPTURE_EN
    output logic               errValid,
    output logic [CNT_W-1:0]   errIndex,
    output logic [8*LANES-1:0] errGot,
    output logic [8*LANES-1:0] errExp,
`endif
    output logic               busy
);
    localparam int unsigned DW = 8 * LANES;

    logic [DW-1:0] head;
    logic          fifo_full, fifo_empty;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (rxClkLcl),
        .rst_n    (rstN),
        .clr      (clear),
        .push     (expValid && expReady && !clear),
        .pop      (rxDataValid && !clear),
        .wdata    (expData),
        .rdata    (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .can_push (expReady)
    );

    // Registered compare stage; FSM and counters act on this delayed beat.
    logic cmp_valid_q, cmp_last_q, cmp_err_q, cmp_under_q;
`ifdef RX_STREAM_CHECKER_ERR_CAPTURE_EN
    logic [DW-1:0] cmp_got_q, cmp_exp_q;
`endif

    // Compare received beat with FIFO head; empty FIFO is an underflow (no bypass).
    always_ff @(posedge rxClkLcl or negedge rstN) begin
        if (!rstN) begin
            cmp_valid_q <= 1'b0;
            cmp_last_q  <= 1'b0;
            cmp_err_q   <= 1'b0;
            cmp_under_q <= 1'b0;
`ifdef RX_STREAM_CHECKER_ERR_CAPTURE_EN
            cmp_got_q   <= '0;
            cmp_exp_q   <= '0;
`endif
        end else if (clear) begin
            cmp_valid_q <= 1'b0;
            cmp_last_q  <= 1'b0;
            cmp_err_q   <= 1'b0;
            cmp_under_q <= 1'b0;
`ifdef RX_STREAM_CHECKER_ERR_CAPTURE_EN
            cmp_got_q   <= '0;
            cmp_exp_q   <= '0;
`endif
        end else begin
            cmp_valid_q <= rxDataValid;
            cmp_last_q  <= rxDataValid && rxLast;
            cmp_err_q   <= rxDataValid && (fifo_empty || (rxData != head));
            cmp_under_q <= rxDataValid && fifo_empty;
`ifdef RX_STREAM_CHECKER_ERR_CAPTURE_EN
            cmp_got_q   <= rxData;
            cmp_exp_q   <= fifo_empty ? '0 : head;
`endif
        end
    end

    chk_state_e       state_q, state_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] match_q, err_q, frames_q;
    logic             underflow_q;

    // Frame FSM: a beat seen in DONE starts the next frame immediately.
    always_comb begin
        state_d     = state_q;
        frame_err_d = frame_err_q;
        unique case (state_q)
            IDLE: begin
                frame_err_d = cmp_err_q;
                if (cmp_valid_q) state_d = cmp_last_q ? DONE : ACTIVE;
            end
            ACTIVE: begin
                frame_err_d = frame_err_q | cmp_err_q;
                if (cmp_last_q) state_d = DONE;
            end
            DONE: begin
                frame_err_d = cmp_err_q;
                if (cmp_valid_q) state_d = cmp_last_q ? DONE : ACTIVE;
                else             state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                frame_err_d = 1'b0;
            end
        endcase
    end

    // State, frame error flag and saturating counters.
    always_ff @(posedge rxClkLcl or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b0;
            match_q     <= '0;
            err_q       <= '0;
            frames_q    <= '0;
            underflow_q <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b0;
            match_q     <= '0;
            err_q       <= '0;
            frames_q    <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
            if (cmp_valid_q && !cmp_err_q) match_q <= CNT_W'(sat_inc(64'(match_q), CNT_W));
            if (cmp_err_q)                 err_q   <= CNT_W'(sat_inc(64'(err_q), CNT_W));
            if (state_q == DONE)          frames_q <= CNT_W'(sat_inc(64'(frames_q), CNT_W));
            if (cmp_under_q)               underflow_q <= 1'b1;
        end
    end

`ifdef RX_STREAM_CHECKER_ERR_CAPTURE_EN
    logic [CNT_W-1:0] beat_idx_q, cur_idx;
    logic             err_valid_q;
    logic [CNT_W-1:0] err_index_q;
    logic [DW-1:0]    err_got_q, err_exp_q;

    // Beat index within the current frame restarts at 0 outside ACTIVE.
    assign cur_idx = (state_q == ACTIVE) ? beat_idx_q : '0;

    // Capture the first error since reset/clear; later errors leave it alone.
    always_ff @(posedge rxClkLcl or negedge rstN) begin
        if (!rstN) begin
            beat_idx_q  <= '0;
            err_valid_q <= 1'b0;
            err_index_q <= '0;
            err_got_q   <= '0;
            err_exp_q   <= '0;
        end else if (clear) begin
            beat_idx_q  <= '0;
            err_valid_q <= 1'b0;
            err_index_q <= '0;
            err_got_q   <= '0;
            err_exp_q   <= '0;
        end else begin
            if (cmp_valid_q) beat_idx_q <= CNT_W'(sat_inc(64'(cur_idx), CNT_W));
            else             beat_idx_q <= cur_idx;
            if (cmp_err_q && !err_valid_q) begin
                err_valid_q <= 1'b1;
                err_index_q <= cur_idx;
                err_got_q   <= cmp_got_q;
                err_exp_q   <= cmp_exp_q;
            end
        end
    end

    assign errValid = err_valid_q;
    assign errIndex = err_index_q;
    assign errGot   = err_got_q;
    assign errExp   = err_exp_q;
`endif

    assign frameDone = (state_q == DONE);
    assign frameOk   = (state_q == DONE) && !frame_err_q;
    assign busy      = (state_q == ACTIVE);
    assign matchCnt  = match_q;
    assign errCnt    = err_q;
    assign frameCnt  = frames_q;
    assign underflow = underflow_q;

endmodule
